operand_fetch: RTL and testbench

//  Read stage directly downstream of the 16x16 register bank. Accepts a decoded instruction
//  (opcode, Rdest/Rsrc addresses, immediate) and selects two operands from the flattened

---
 rtl/operand_fetch_pkg.sv | 22 ++
 rtl/operand_fetch_if.sv | 37 +++
 rtl/operand_sel.sv | 22 ++
 rtl/operand_fetch.sv | 78 +++++++
 tb/tb_operand_fetch.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared widths and the pipeline slot layout for the operand-fetch stage.
// Imported by the interface, the operand mux and the stage top.
package operand_fetch_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int NREG   = 2 ** ADDR_W;
    localparam int OP_W   = 8;

    // One held instruction. rsrc and use_imm are internal: they only steer the
    // stall refresh of operand B and are not visible at the ports.
    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   opcode;
        logic [ADDR_W-1:0] rdest;
        logic [ADDR_W-1:0] rsrc;
        logic              use_imm;
        logic [DATA_W-1:0] opa;
        logic [DATA_W-1:0] opb;
    } slot_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Upstream instruction handshake, register-bank snoop and downstream ALU handshake.
// The master side drives instructions and the bank; the slave side is the fetch stage.
interface operand_fetch_if;
    import operand_fetch_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [OP_W-1:0]        in_opcode;
    logic [ADDR_W-1:0]      in_rdest;
    logic [ADDR_W-1:0]      in_rsrc;
    logic                   in_use_imm;
    logic [DATA_W-1:0]      in_imm;

    logic [NREG*DATA_W-1:0] regs_flat;
    logic [DATA_W-1:0]      MainBus;
    logic [NREG-1:0]        regEnable;

    logic                   out_valid;
    logic                   out_ready;
    logic [OP_W-1:0]        out_opcode;
    logic [ADDR_W-1:0]      out_rdest;
    logic [DATA_W-1:0]      out_opa;
    logic [DATA_W-1:0]      out_opb;

    modport master (
        output in_valid, in_opcode, in_rdest, in_rsrc, in_use_imm, in_imm,
        output regs_flat, MainBus, regEnable, out_ready,
        input  in_ready, out_valid, out_opcode, out_rdest, out_opa, out_opb
    );

    modport slave (
        input  in_valid, in_opcode, in_rdest, in_rsrc, in_use_imm, in_imm,
        input  regs_flat, MainBus, regEnable, out_ready,
        output in_ready, out_valid, out_opcode, out_rdest, out_opa, out_opb
    );

endinterface

// File: rtl/operand_sel.sv
// Combinational NREG:1 register read mux; a same-cycle bank write to the
// selected register overrides the stored value with the write data.
module operand_sel
    import operand_fetch_pkg::*;
(
    input  logic [ADDR_W-1:0]      addr,
    input  logic [NREG*DATA_W-1:0] regs_flat,
    input  logic [DATA_W-1:0]      MainBus,
    input  logic [NREG-1:0]        regEnable,
    output logic [DATA_W-1:0]      value
);

    always_comb begin
        // NOTE: assign the default first so every path drives value; a missing
        // branch in always_comb would otherwise infer a latch.
        value = regs_flat[DATA_W*int'(addr) +: DATA_W];
        if (regEnable[addr]) begin
            value = MainBus;
        end
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: selects A/B operands from the register bank with write
// forwarding and holds them in a single valid/ready slot feeding the ALU.
module operand_fetch
    import operand_fetch_pkg::*;
(
    input logic            clk,
    input logic            reset,
    operand_fetch_if.slave bus
);

    slot_t             slot;
    logic              accept;
    logic              stall;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    assign bus.in_ready = !slot.valid || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign stall        = slot.valid && !bus.out_ready;

    // The muxes look at the incoming addresses on capture and at the held
    // addresses otherwise, so the same forwarding logic serves the refresh.
    assign addr_a = accept ? bus.in_rdest : slot.rdest;
    assign addr_b = accept ? bus.in_rsrc  : slot.rsrc;

    operand_sel u_sel_a (
        .addr      (addr_a),
        .regs_flat (bus.regs_flat),
        .MainBus   (bus.MainBus),
        .regEnable (bus.regEnable),
        .value     (sel_a)
    );

    operand_sel u_sel_b (
        .addr      (addr_b),
        .regs_flat (bus.regs_flat),
        .MainBus   (bus.MainBus),
        .regEnable (bus.regEnable),
        .value     (sel_b)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: unlike a memory array, the slot data is reset because it
            // drives the outputs, which must read zero straight out of reset.
            slot <= '0;
        end else if (accept) begin
            slot.valid   <= 1'b1;
            slot.opcode  <= bus.in_opcode;
            slot.rdest   <= bus.in_rdest;
            slot.rsrc    <= bus.in_rsrc;
            slot.use_imm <= bus.in_use_imm;
            slot.opa     <= sel_a;
            slot.opb     <= bus.in_use_imm ? bus.in_imm : sel_b;
        end else if (stall) begin
            // A held operand tracks writes to its register; an immediate never does.
            if (bus.regEnable[slot.rdest]) begin
                slot.opa <= sel_a;
            end
            if (!slot.use_imm && bus.regEnable[slot.rsrc]) begin
                slot.opb <= sel_b;
            end
        end else begin
            slot.valid <= 1'b0;
        end
    end

    assign bus.out_valid  = slot.valid;
    assign bus.out_opcode = slot.opcode;
    assign bus.out_rdest  = slot.rdest;
    assign bus.out_opa    = slot.opa;
    assign bus.out_opb    = slot.opb;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: models the register bank and the one-deep slot as a
// queue, compares every negedge, and pins the model with directed literal checks.
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    typedef struct {
        logic [OP_W-1:0]   op;
        logic [ADDR_W-1:0] rd;
        logic [ADDR_W-1:0] rs;
        logic              ui;
        logic [DATA_W-1:0] imm;
    } instr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_pushed = 0;
    int   n_popped = 0;

    logic [DATA_W-1:0] bank [NREG];
    instr_t            q [$];

    always #5 clk = ~clk;

    operand_fetch_if bus ();

    operand_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [DATA_W-1:0] init_val(int k);
        case (k)
            3:       return 16'h1234;
            5:       return 16'h00FF;
            7:       return 16'h0001;
            default: return 16'(k * 16'h0101 + 16'h0010);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register bank behaviour: a written register holds MainBus after the edge.
    always_comb begin
        for (int k = 0; k < NREG; k++) begin
            bus.regs_flat[k*DATA_W +: DATA_W] = bank[k];
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < NREG; k++) begin
            if (reset) bank[k] <= init_val(k);
            else if (bus.regEnable[k]) bank[k] <= bus.MainBus;
        end
    end

    // Slot model: a queue of at most one instruction.
    always @(posedge clk or posedge reset) begin
        bit pop_now;
        bit push_now;
        if (reset) begin
            q.delete();
        end else begin
            pop_now  = (q.size() != 0) && bus.out_ready;
            push_now = bus.in_valid && ((q.size() == 0) || bus.out_ready);
            if (pop_now) begin
                void'(q.pop_front());
                n_popped++;
            end
            if (push_now) begin
                q.push_back('{op: bus.in_opcode, rd: bus.in_rdest, rs: bus.in_rsrc,
                              ui: bus.in_use_imm, imm: bus.in_imm});
                n_pushed++;
            end
        end
    end

    // Held operands must always equal the current bank contents of their registers.
    always @(negedge clk) begin
        if (!reset) begin
            check("in_ready", 32'(bus.in_ready), 32'((q.size() == 0) || bus.out_ready));
            check("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                check("out_opcode", 32'(bus.out_opcode), 32'(q[0].op));
                check("out_rdest", 32'(bus.out_rdest), 32'(q[0].rd));
                check("out_opa", 32'(bus.out_opa), 32'(bank[q[0].rd]));
                check("out_opb", 32'(bus.out_opb), 32'(q[0].ui ? q[0].imm : bank[q[0].rs]));
            end
        end
    end

    task automatic set_in(input logic v, input logic [7:0] op, input logic [3:0] rd,
                          input logic [3:0] rs, input logic ui, input logic [15:0] imm);
        bus.in_valid   = v;
        bus.in_opcode  = op;
        bus.in_rdest   = rd;
        bus.in_rsrc    = rs;
        bus.in_use_imm = ui;
        bus.in_imm     = imm;
    endtask

    task automatic set_wr(input logic [15:0] ren, input logic [15:0] mb);
        bus.regEnable = ren;
        bus.MainBus   = mb;
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int base_pushed;
        bit acc;
        bit rdy_toggle;
        int tries;

        set_in(1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 16'h0000);
        set_wr(16'h0000, 16'h0000);
        bus.out_ready = 1'b1;
        #12;
        reset = 1'b0;

        // Plain read of r3 / r5.
        set_in(1'b1, 8'h11, 4'd3, 4'd5, 1'b0, 16'h0000);
        tick();
        check("plain_opa", 32'(bus.out_opa), 32'h1234);
        check("plain_opb", 32'(bus.out_opb), 32'h00FF);
        check("plain_valid", 32'(bus.out_valid), 32'h1);
        check("plain_in_ready", 32'(bus.in_ready), 32'h1);

        // Same-cycle write to r7 forwarded into operand A.
        set_in(1'b1, 8'h22, 4'd7, 4'd5, 1'b0, 16'h0000);
        set_wr(16'h0080, 16'hBEEF);
        tick();
        check("fwd_opa", 32'(bus.out_opa), 32'hBEEF);
        check("fwd_opcode", 32'(bus.out_opcode), 32'h22);

        // Stall refresh of both register-sourced operands.
        set_wr(16'h0000, 16'h0000);
        set_in(1'b1, 8'h33, 4'd2, 4'd4, 1'b0, 16'h0000);
        tick();
        bus.out_ready = 1'b0;
        set_in(1'b1, 8'h44, 4'd9, 4'd4, 1'b1, 16'hFFF0);
        set_wr(16'h0014, 16'h5A5A);
        tick();
        check("refresh_opa", 32'(bus.out_opa), 32'h5A5A);
        check("refresh_opb", 32'(bus.out_opb), 32'h5A5A);
        check("refresh_in_ready", 32'(bus.in_ready), 32'h0);
        check("refresh_opcode", 32'(bus.out_opcode), 32'h33);
        set_wr(16'h0000, 16'h0000);
        tick();
        check("stall_in_ready", 32'(bus.in_ready), 32'h0);
        check("stall_hold_opa", 32'(bus.out_opa), 32'h5A5A);

        // Release: pop the stalled entry and capture the immediate instruction.
        bus.out_ready = 1'b1;
        tick();
        check("imm_opcode", 32'(bus.out_opcode), 32'h44);
        check("imm_opb", 32'(bus.out_opb), 32'hFFF0);

        // A write to the immediate's rsrc during a stall must not touch operand B.
        set_in(1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 16'h0000);
        bus.out_ready = 1'b0;
        set_wr(16'h0010, 16'h1357);
        tick();
        check("imm_no_refresh", 32'(bus.out_opb), 32'hFFF0);
        set_wr(16'h0000, 16'h0000);
        bus.out_ready = 1'b1;
        tick();
        check("pop_valid", 32'(bus.out_valid), 32'h0);
        check("pop_keeps_opb", 32'(bus.out_opb), 32'hFFF0);

        // Back-to-back stream with writes, including rdest==rsrc and multi-hot enables.
        base_pushed = n_pushed;
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 8'(8'h60 + i), 4'(i), (i == 3) ? 4'd3 : 4'(15 - i), 1'b0, 16'h0000);
            if (i % 2 == 0) set_wr(16'h8000 | (16'h0001 << i), 16'(16'hA000 + i));
            else            set_wr(16'h0000, 16'h0000);
            tick();
        end

        // Toggling out_ready; upstream holds each instruction until it is taken.
        rdy_toggle = 1'b0;
        for (int j = 0; j < 8; j++) begin
            set_in(1'b1, 8'(8'h80 + j), 4'(j + 4), 4'(j), 1'(j % 2), 16'(16'hC000 + j));
            acc = 1'b0;
            tries = 0;
            while (!acc && tries < 20) begin
                bus.out_ready = rdy_toggle;
                rdy_toggle = ~rdy_toggle;
                set_wr((j % 3 == 0) ? 16'h0033 : 16'h0000, 16'(16'hD000 + j * 16 + tries));
                #1;
                acc = bus.in_valid && bus.in_ready;
                tick();
                tries++;
            end
            if (!acc) check("accept_timeout", 32'h0, 32'h1);
        end

        // Drain with a bounded wait.
        set_in(1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 16'h0000);
        set_wr(16'h0000, 16'h0000);
        bus.out_ready = 1'b1;
        tries = 0;
        while (bus.out_valid && tries < 10) begin
            tick();
            tries++;
        end
        check("drain_done", 32'(bus.out_valid), 32'h0);
        check("stream_pushed", 32'(n_pushed - base_pushed), 32'd16);
        check("stream_popped", 32'(n_popped), 32'(n_pushed));

        // Asynchronous reset mid-stall clears the slot before any edge.
        set_in(1'b1, 8'h77, 4'd3, 4'd5, 1'b0, 16'h0000);
        tick();
        set_in(1'b0, 8'h00, 4'd0, 4'd0, 1'b0, 16'h0000);
        bus.out_ready = 1'b0;
        tick();
        check("pre_reset_valid", 32'(bus.out_valid), 32'h1);
        check("pre_reset_opcode", 32'(bus.out_opcode), 32'h77);
        #2;
        reset = 1'b1;
        #1;
        check("reset_valid", 32'(bus.out_valid), 32'h0);
        check("reset_opcode", 32'(bus.out_opcode), 32'h0);
        check("reset_rdest", 32'(bus.out_rdest), 32'h0);
        check("reset_opa", 32'(bus.out_opa), 32'h0);
        check("reset_opb", 32'(bus.out_opb), 32'h0);
        check("reset_in_ready", 32'(bus.in_ready), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
